// File: rtl/cam_capture_rgb332.sv
// ============================================================================
// cam_capture_rgb332 : OV7670 RGB565 capture -> RGB332 frame-buffer writer
// Optional build macro CAM_TEST_PATTERN_EN replaces camera data with a grid.
// Rev 1.0
// ============================================================================
`default_nettype none

module cam_capture_rgb332 #(
  parameter int CAM_SCREEN_X = 160,
  parameter int CAM_SCREEN_Y = 120,
  parameter int AW           = 15,
  parameter int DW           = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CAM_pclk,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [DW-1:0] DP_RAM_data_in,
  output logic          DP_RAM_regW,
  output logic          frame_done
);

  localparam logic [15:0]   c_X    = 16'(CAM_SCREEN_X);
  localparam logic [15:0]   c_Y    = 16'(CAM_SCREEN_Y);
  localparam logic [AW-1:0] c_X_AW = AW'(CAM_SCREEN_X);

  typedef enum logic [1:0] {
    S_WAIT_FRAME = 2'd0,
    S_BYTE1      = 2'd1,
    S_BYTE2      = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic r_pclk_m, r_pclk_s, r_pclk_d;
  logic r_vs_m, r_vs_s, r_vs_d;
  logic r_href_m, r_href_s, r_href_d;
  logic [7:0] r_data_m, r_data_s;

  logic [7:0]    r_b1;
  logic [15:0]   r_col, r_row;
  logic [AW-1:0] r_line_base;
  logic          r_pend;
  logic [AW-1:0] r_pend_addr;
  logic [DW-1:0] r_pend_data;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_regW, r_frame_done;

  logic w_byte_ev, w_vs_rise, w_vs_fall, w_href_fall, w_in_cap;
  logic w_start, w_first, w_capture, w_line_end, w_fd, w_in_range;
  logic [7:0] w_pix;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pclk_m <= 1'b0; r_pclk_s <= 1'b0; r_pclk_d <= 1'b0;
      r_vs_m   <= 1'b0; r_vs_s   <= 1'b0; r_vs_d   <= 1'b0;
      r_href_m <= 1'b0; r_href_s <= 1'b0; r_href_d <= 1'b0;
      r_data_m <= 8'd0; r_data_s <= 8'd0;
    end else begin
      r_pclk_m <= CAM_pclk;    r_pclk_s <= r_pclk_m; r_pclk_d <= r_pclk_s;
      r_vs_m   <= CAM_vsync;   r_vs_s   <= r_vs_m;   r_vs_d   <= r_vs_s;
      r_href_m <= CAM_href;    r_href_s <= r_href_m; r_href_d <= r_href_s;
      r_data_m <= CAM_px_data; r_data_s <= r_data_m;
    end
  end

  assign w_byte_ev   = r_pclk_s & ~r_pclk_d;
  assign w_vs_rise   = r_vs_s & ~r_vs_d;
  assign w_vs_fall   = ~r_vs_s & r_vs_d;
  assign w_href_fall = ~r_href_s & r_href_d;
  assign w_in_cap    = (r_state == S_BYTE1) || (r_state == S_BYTE2);

  // vsync rise outranks href fall, which outranks a byte event
  assign w_start    = (r_state == S_WAIT_FRAME) && w_vs_fall;
  assign w_fd       = w_in_cap && w_vs_rise;
  assign w_line_end = w_in_cap && !w_vs_rise && w_href_fall;
  assign w_first    = (r_state == S_BYTE1) && !w_vs_rise && !w_href_fall
                      && w_byte_ev && r_href_s;
  assign w_capture  = (r_state == S_BYTE2) && !w_vs_rise && !w_href_fall
                      && w_byte_ev && r_href_s;
  assign w_in_range = (r_col < c_X) && (r_row < c_Y);

`ifdef CAM_TEST_PATTERN_EN
  assign w_pix = {r_col[6:4], r_row[6:4], 2'b11};
`else
  assign w_pix = {r_b1[7:5], r_b1[2:0], r_data_s[4:3]};
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_WAIT_FRAME;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_FRAME: if (w_vs_fall) w_state_nxt = S_BYTE1;
      S_BYTE1: begin
        if (w_vs_rise)                     w_state_nxt = S_WAIT_FRAME;
        else if (w_href_fall)              w_state_nxt = S_BYTE1;
        else if (w_byte_ev && r_href_s)    w_state_nxt = S_BYTE2;
      end
      S_BYTE2: begin
        if (w_vs_rise)                     w_state_nxt = S_WAIT_FRAME;
        else if (w_href_fall)              w_state_nxt = S_BYTE1;
        else if (w_byte_ev && r_href_s)    w_state_nxt = S_BYTE1;
      end
      default:                             w_state_nxt = S_WAIT_FRAME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_b1         <= 8'd0;
      r_col        <= 16'd0;
      r_row        <= 16'd0;
      r_line_base  <= '0;
      r_pend       <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_data  <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_regW       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_fd;
      r_regW       <= r_pend;
      r_pend       <= 1'b0;
      if (r_pend) begin
        r_addr <= r_pend_addr;
        r_data <= r_pend_data;
      end
      if (w_start) begin
        r_col       <= 16'd0;
        r_row       <= 16'd0;
        r_line_base <= '0;
      end
      if (w_first) r_b1 <= r_data_s;
      // Converted pixel is staged one clk, then committed only if on-screen
      if (w_capture) begin
        r_pend      <= w_in_range;
        r_pend_addr <= r_line_base + AW'(r_col);
        r_pend_data <= DW'(w_pix);
        if (r_col != c_X) r_col <= r_col + 16'd1;
      end
      if (w_line_end) begin
        r_col <= 16'd0;
        if (r_row != c_Y) begin
          r_row       <= r_row + 16'd1;
          r_line_base <= r_line_base + c_X_AW;
        end
      end
    end
  end

  assign DP_RAM_addr_in = r_addr;
  assign DP_RAM_data_in = r_data;
  assign DP_RAM_regW    = r_regW;
  assign frame_done     = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_cam_capture_rgb332.sv
// ============================================================================
// tb_cam_capture_rgb332 : scoreboard bench for the RGB332 camera capture block
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cam_capture_rgb332;

  localparam int X  = 20;
  localparam int Y  = 6;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, pclk, vsync, href;
  logic [7:0]    pxd;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          regw, fd;

  cam_capture_rgb332 #(.CAM_SCREEN_X(X), .CAM_SCREEN_Y(Y), .AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .CAM_pclk       (pclk),
    .CAM_vsync      (vsync),
    .CAM_href       (href),
    .CAM_px_data    (pxd),
    .DP_RAM_addr_in (addr),
    .DP_RAM_data_in (data),
    .DP_RAM_regW    (regw),
    .frame_done     (fd)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_b2_rise = 0;
  int n_wr = 0, n_fd = 0;
  int exp_wr = 0, exp_fd = 0;
  int m_row = 0, m_col = 0;
  bit m_active = 1'b0;
  logic prev_regw = 1'b0, prev_fd = 1'b0;
  logic [15:0] q_exp[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [15:0] e;
    if (regw) begin
      if (q_exp.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        e = q_exp.pop_front();
        chk("wr_addr", 32'(addr), 32'(e[15:8]));
        chk("wr_data", 32'(data), 32'(e[7:0]));
        chk("wr_latency", 32'(cyc - last_b2_rise), 32'd4);
      end
      n_wr <= n_wr + 1;
    end
    if (regw && prev_regw) chk("regw_pulse_width", 32'd2, 32'd1);
    if (fd && prev_fd)     chk("fd_pulse_width", 32'd2, 32'd1);
    if (fd) n_fd <= n_fd + 1;
    prev_regw <= regw;
    prev_fd   <= fd;
  end

  task automatic cam_byte(input logic [7:0] b, input bit is_b2);
    @(negedge clk); pclk = 1'b0; pxd = b; href = 1'b1;
    @(negedge clk);
    @(negedge clk); pclk = 1'b1; if (is_b2) last_b2_rise = cyc;
    @(negedge clk);
  endtask

  task automatic push_pix(input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] d;
    logic [6:0] c7, r7;
    c7 = m_col[6:0];
    r7 = m_row[6:0];
`ifdef CAM_TEST_PATTERN_EN
    d = {c7[6:4], r7[6:4], 2'b11};
`else
    d = {b1[7:5], b1[2:0], b2[4:3]};
`endif
    if (m_active && m_col < X && m_row < Y) begin
      q_exp.push_back({8'(m_row * X + m_col), d});
      exp_wr++;
    end
    if (m_active) m_col++;
  endtask

  task automatic pix(input logic [7:0] b1, input logic [7:0] b2);
    cam_byte(b1, 1'b0);
    push_pix(b1, b2);
    cam_byte(b2, 1'b1);
  endtask

  task automatic end_line();
    repeat (2) @(negedge clk);
    href = 1'b0;
    repeat (8) @(negedge clk);
    if (m_active) begin
      m_col = 0;
      if (m_row < Y) m_row++;
    end
  endtask

  task automatic send_line(input int npix, input int drop_at, input bit fixed);
    logic [7:0] b1, b2;
    for (int p = 0; p < npix; p++) begin
      b1 = fixed ? 8'hF8 : 8'($urandom);
      b2 = fixed ? 8'h1F : 8'($urandom);
      if (p == drop_at) begin
        cam_byte(b1, 1'b0);
        break;
      end
      pix(b1, b2);
    end
    end_line();
  endtask

  task automatic vs_pulse();
    @(negedge clk); vsync = 1'b1;
    repeat (4) @(negedge clk);
    if (m_active) exp_fd++;
    m_active = 1'b0;
    repeat (6) @(negedge clk);
    vsync = 1'b0;
    repeat (8) @(negedge clk);
    m_active = 1'b1;
    m_row = 0;
    m_col = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_regw", 32'(regw), 32'd0);
    chk("rst_fd",   32'(fd),   32'd0);
    rst = 1'b0;
    m_active = 1'b0;
    m_row = 0;
    m_col = 0;
  endtask

  initial begin
    rst = 1'b1; pclk = 1'b0; vsync = 1'b0; href = 1'b0; pxd = 8'd0;
    do_reset();

    // Line with no preceding vsync: must never be written
    send_line(4, -1, 1'b0);

    // Frame 1: full, clipped-long, dropped-partial, short and off-screen lines
    vs_pulse();
    send_line(X, -1, 1'b1);
    send_line(X + 5, -1, 1'b0);
    send_line(8, 5, 1'b0);
    send_line(X, -1, 1'b0);
    send_line(7, -1, 1'b0);
    send_line(X, -1, 1'b0);
    send_line(3, -1, 1'b0);
    vs_pulse();
    repeat (4) @(negedge clk);
    chk("frame1_writes", 32'(n_wr), 32'd92);
    chk("frame1_done", 32'(n_fd), 32'd1);

    // Frame 2 aborted by reset mid-line
    send_line(X, -1, 1'b0);
    for (int p = 0; p < 3; p++) pix(8'($urandom), 8'($urandom));
    repeat (8) @(negedge clk);
    do_reset();
    chk("q_empty_after_rst", 32'(q_exp.size()), 32'd0);
    for (int p = 0; p < 4; p++) pix(8'($urandom), 8'($urandom));
    end_line();
    send_line(5, -1, 1'b0);
    vs_pulse();

    // Frame 3: capture resumes at address 0
    send_line(5, -1, 1'b1);
    vs_pulse();

    repeat (20) @(negedge clk);
    chk("q_empty_end", 32'(q_exp.size()), 32'd0);
    chk("total_writes", 32'(n_wr), 32'(exp_wr));
    chk("total_frame_done", 32'(n_fd), 32'(exp_fd));
    chk("frame_done_count", 32'(n_fd), 32'd2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
